// File: rtl/encoder_pass_ctrl.sv
// Pass sequencer for the encoder: loads a host word into the ping-pong working RAMs,
// runs grouper merge passes until the word stops shrinking, then streams the result out.
module encoder_pass_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_PASSES = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    input  logic                            load_valid,
    input  logic [DATA_WIDTH-1:0]           load_data,
    output logic                            load_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            grp_cs,
    input  logic                            grp_done,
    input  logic                            grp_merged,
    input  logic [ADDR_WIDTH:0]             grp_len,
    output logic [ADDR_WIDTH:0]             grp_len_in,
    output logic                            src_sel,
    output logic                            ram_own,
    output logic                            ram_we,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_din,
    input  logic [DATA_WIDTH-1:0]           ram_dout,
    output logic [$clog2(MAX_PASSES+1)-1:0] pass_count,
    output logic [2:0]                      dbg_state
);
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int PC_W  = $clog2(MAX_PASSES + 1);
    localparam logic [LEN_W-1:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PC_W-1:0]  MAXP_C   = PC_W'(MAX_PASSES);

    typedef enum logic [2:0] {
        S_IDLE, S_PASS_START, S_PASS_WAIT, S_DRAIN, S_DONE
    } state_t;
    typedef enum logic [1:0] {D_READ, D_WAIT, D_HOLD} dphase_t;

    state_t                  state_q, state_d;
    dphase_t                 dphase_q, dphase_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [PC_W-1:0]         pass_count_q, pass_count_d;
    logic                    src_sel_q, src_sel_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    load_ready_q, load_ready_d;
    logic                    grp_cs_q, grp_cs_d;
    logic                    ram_own_q, ram_own_d;
    logic [LEN_W-1:0]        grp_len_in_q, grp_len_in_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

    logic                    load_fire;
    logic [LEN_W-1:0]        len_plus;
    logic                    go_pass, go_drain, go_done;
    logic [LEN_W-1:0]        pass_len;

    // Both host ports use valid/ready: a transfer happens on a rising edge where
    // valid && ready; the producer holds its data stable until that edge.
    assign load_fire = (state_q == S_IDLE) && load_valid && load_ready_q && !rst;
    assign len_plus  = load_fire ? len_q + LEN_W'(1) : len_q;

    always_comb begin
        state_d      = state_q;
        dphase_d     = dphase_q;
        len_d        = len_q;
        pass_count_d = pass_count_q;
        src_sel_d    = src_sel_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_ready_d = load_ready_q;
        grp_cs_d     = 1'b0;
        ram_own_d    = ram_own_q;
        grp_len_in_d = grp_len_in_q;
        rd_addr_d    = rd_addr_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        go_pass      = 1'b0;
        go_drain     = 1'b0;
        go_done      = 1'b0;
        pass_len     = len_q;

        case (state_q)
            S_IDLE: begin
                len_d        = len_plus;
                load_ready_d = (len_plus < FULL_LEN);
                if (start) begin
                    busy_d       = 1'b1;
                    load_ready_d = 1'b0;
                    if (len_plus == '0) begin
                        go_done = 1'b1;
                    end else if (len_plus == LEN_W'(1)) begin
                        go_drain = 1'b1;
                    end else begin
                        go_pass  = 1'b1;
                        pass_len = len_plus;
                    end
                end
            end
            S_PASS_START: state_d = S_PASS_WAIT;
            S_PASS_WAIT: begin
                if (grp_done) begin
                    src_sel_d = ~src_sel_q;
                    // A pass can never grow the word; treat that as corrupt and stop.
                    if (grp_len > len_q) begin
                        go_drain = 1'b1;
                    end else begin
                        len_d = grp_len;
                        if (!grp_merged || grp_len <= LEN_W'(1) || pass_count_q == MAXP_C) begin
                            if (grp_len == '0) go_done = 1'b1;
                            else               go_drain = 1'b1;
                        end else begin
                            go_pass  = 1'b1;
                            pass_len = grp_len;
                        end
                    end
                end
            end
            S_DRAIN: begin
                case (dphase_q)
                    D_READ: dphase_d = D_WAIT;
                    D_WAIT: begin
                        out_data_d  = ram_dout;
                        out_valid_d = 1'b1;
                        out_last_d  = ({1'b0, rd_addr_q} == (len_q - LEN_W'(1)));
                        dphase_d    = D_HOLD;
                    end
                    D_HOLD: begin
                        if (out_ready) begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            if (out_last_q) begin
                                go_done = 1'b1;
                            end else begin
                                rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                                dphase_d  = D_READ;
                            end
                        end
                    end
                    default: dphase_d = D_READ;
                endcase
            end
            S_DONE: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                len_d        = '0;
                pass_count_d = '0;
                src_sel_d    = 1'b0;
                load_ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (go_pass) begin
            state_d      = S_PASS_START;
            grp_cs_d     = 1'b1;
            ram_own_d    = 1'b0;
            grp_len_in_d = pass_len;
            pass_count_d = pass_count_q + PC_W'(1);
        end
        if (go_drain) begin
            state_d   = S_DRAIN;
            dphase_d  = D_READ;
            rd_addr_d = '0;
            ram_own_d = 1'b1;
        end
        if (go_done) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            ram_own_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dphase_q     <= D_READ;
            len_q        <= '0;
            pass_count_q <= '0;
            src_sel_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
            grp_cs_q     <= 1'b0;
            ram_own_q    <= 1'b1;
            grp_len_in_q <= '0;
            rd_addr_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            dphase_q     <= dphase_d;
            len_q        <= len_d;
            pass_count_q <= pass_count_d;
            src_sel_q    <= src_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
            grp_cs_q     <= grp_cs_d;
            ram_own_q    <= ram_own_d;
            grp_len_in_q <= grp_len_in_d;
            rd_addr_q    <= rd_addr_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
        end
    end

    // Loads write at the current length; drains read through the drain pointer.
    assign ram_we     = load_fire;
    assign ram_din    = load_data;
    assign ram_addr   = (state_q == S_IDLE) ? len_q[ADDR_WIDTH-1:0] : rd_addr_q;

    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign grp_cs     = grp_cs_q;
    assign grp_len_in = grp_len_in_q;
    assign src_sel    = src_sel_q;
    assign ram_own    = ram_own_q;
    assign pass_count = pass_count_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_encoder_pass_ctrl.sv
// Bench for encoder_pass_ctrl: models both working RAMs and a scripted grouper, and
// scoreboards the drained word against a list-level model of the pass sequence.
module tb_encoder_pass_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int MAXP  = 2;
    localparam int LW    = AW + 1;
    localparam int PCW   = $clog2(MAXP + 1);
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            load_valid = 1'b0;
    logic [DW-1:0]   load_data = '0;
    logic            out_ready = 1'b0;
    logic            grp_done;
    logic            grp_merged;
    logic [LW-1:0]   grp_len;
    logic [DW-1:0]   ram_dout;
    logic            busy, done, load_ready, out_valid, out_last, grp_cs;
    logic            src_sel, ram_own, ram_we;
    logic [DW-1:0]   out_data, ram_din;
    logic [LW-1:0]   grp_len_in;
    logic [AW-1:0]   ram_addr;
    logic [PCW-1:0]  pass_count;
    logic [2:0]      dbg_state;

    encoder_pass_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PASSES(MAXP)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_last(out_last),
        .grp_cs(grp_cs), .grp_done(grp_done), .grp_merged(grp_merged), .grp_len(grp_len),
        .grp_len_in(grp_len_in), .src_sel(src_sel), .ram_own(ram_own), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .pass_count(pass_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW:0]   exp_q[$];
    logic [LW-1:0] glen_q[$];
    logic [LW:0]   gscript_q[$];
    int exp_passes = 0;
    int exp_src = 0;
    int cs_base = 0;
    int grp_cs_cnt = 0;
    int done_cnt = 0;
    int ready_mode = 2;

    logic [DW-1:0] tok[DEPTH];
    logic          sm[MAXP];
    int            sl[MAXP];
    logic [DW-1:0] mem0[DEPTH];
    logic [DW-1:0] mem1[DEPTH];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // RAM pair plus a grouper that applies the scripted pass from src to dest.
    logic          g_busy = 1'b0;
    int            g_wait = 0;
    logic          g_src = 1'b0;
    always @(posedge clk) begin : env
        logic [LW:0]   cmd;
        logic [DW-1:0] v;
        grp_done   <= 1'b0;
        grp_merged <= 1'b0;
        grp_len    <= '0;
        if (ram_own) begin
            ram_dout <= src_sel ? mem1[ram_addr] : mem0[ram_addr];
            if (ram_we) begin
                if (src_sel) mem1[ram_addr] = ram_din;
                else         mem0[ram_addr] = ram_din;
            end
        end
        if (grp_cs) begin
            grp_cs_cnt++;
            g_busy = 1'b1;
            g_wait = $urandom_range(2, 6);
            g_src  = src_sel;
            check("grp_cs_ram_own", {31'd0, ram_own}, 32'd0);
            if (glen_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL grp_cs_unexpected: got a grouper start, expected none at %0t", $time);
            end else begin
                check("grp_len_in", grp_len_in, glen_q.pop_front());
            end
        end else if (g_busy) begin
            if (g_wait > 0) begin
                g_wait--;
            end else begin
                g_busy = 1'b0;
                cmd = (gscript_q.size() > 0) ? gscript_q.pop_front() : '0;
                for (int i = 0; i < int'(cmd[LW-1:0]); i++) begin
                    v = g_src ? mem1[i] : mem0[i];
                    if (cmd[LW]) v = v + DW'(i) + 8'h11;
                    if (g_src) mem0[i] = v;
                    else       mem1[i] = v;
                end
                grp_done   <= 1'b1;
                grp_merged <= cmd[LW];
                grp_len    <= cmd[LW-1:0];
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = ~out_ready;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: pops the scoreboard on each handshake and checks hold stability.
    logic        hold_seen = 1'b0;
    logic [DW:0] hold_val = '0;
    always @(negedge clk) begin
        if (rst) begin
            hold_seen = 1'b0;
        end else begin
            if (hold_seen) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {out_last, out_data}, hold_val);
            end
            hold_seen = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL out_extra: got token 0x%0h, expected no token at %0t", out_data, $time);
                    end else begin
                        check("out_token", {out_last, out_data}, exp_q.pop_front());
                    end
                end else begin
                    hold_seen = 1'b1;
                    hold_val  = {out_last, out_data};
                end
            end
            if (done) begin
                check("done_pass_count", pass_count, exp_passes);
                check("done_src_sel", {31'd0, src_sel}, exp_src);
                check("done_grp_cs_count", grp_cs_cnt - cs_base, exp_passes);
                check("done_tokens_left", exp_q.size(), 0);
                done_cnt++;
            end
        end
    end

    // List-level reference: apply each scripted pass to the word until a stop rule hits.
    task automatic prepare(input int n);
        logic [DW-1:0] cur[DEPTH];
        int clen;
        int passes;
        exp_q.delete();
        glen_q.delete();
        gscript_q.delete();
        for (int i = 0; i < n; i++) cur[i] = tok[i];
        clen   = n;
        passes = 0;
        if (n >= 2) begin
            for (int p = 0; p < MAXP; p++) begin
                passes++;
                glen_q.push_back(LW'(clen));
                gscript_q.push_back({sm[p], LW'(sl[p])});
                for (int i = 0; i < sl[p]; i++) if (sm[p]) cur[i] = cur[i] + DW'(i) + 8'h11;
                clen = sl[p];
                if (!sm[p] || sl[p] <= 1) break;
            end
        end
        for (int i = 0; i < clen; i++) exp_q.push_back({(i == clen - 1), cur[i]});
        exp_passes = passes;
        exp_src    = passes % 2;
        cs_base    = grp_cs_cnt;
    endtask

    task automatic gen_random(input int n);
        int clen;
        for (int i = 0; i < n; i++) tok[i] = DW'($urandom);
        clen = n;
        for (int p = 0; p < MAXP; p++) begin
            sm[p] = 1'($urandom_range(0, 1));
            if (clen == 0)  sl[p] = 0;
            else if (sm[p]) sl[p] = $urandom_range(1, clen);
            else            sl[p] = clen;
            clen = sl[p];
        end
    endtask

    task automatic load_token(input logic [DW-1:0] d, input logic with_start);
        int k;
        load_valid = 1'b1;
        load_data  = d;
        start      = with_start;
        k = 0;
        while (!load_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!load_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL load_timeout: load_ready stayed 0, expected 1 at %0t", $time);
        end
        @(negedge clk);
        load_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_all(input int n, input logic same);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            load_token(tok[i], same && (i == n - 1));
        end
        if (!(same && n > 0)) pulse_start();
    endtask

    task automatic finish_case(input string name);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == d0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: no done pulse, expected one within 4000 cycles", name);
        end
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_load_ready", {31'd0, load_ready}, 32'd1);
        check("idle_pass_count", pass_count, 32'd0);
        check("idle_src_sel", {31'd0, src_sel}, 32'd0);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_case(input string name, input int n, input logic same);
        prepare(n);
        load_all(n, same);
        finish_case(name);
    endtask

    task automatic check_reset_values();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_grp_cs", {31'd0, grp_cs}, 32'd0);
        check("rst_src_sel", {31'd0, src_sel}, 32'd0);
        check("rst_ram_own", {31'd0, ram_own}, 32'd1);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_pass_count", pass_count, 32'd0);
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int sticky;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values();

        // Two merging passes shrink the word to one token.
        tok[0] = 8'h61; tok[1] = 8'h62; tok[2] = 8'h61; tok[3] = 8'h62;
        sm[0] = 1'b1; sl[0] = 2; sm[1] = 1'b1; sl[1] = 1;
        run_case("two_pass", 4, 1'b0);

        // First pass merges nothing: output is the loaded word read from the other RAM.
        tok[0] = 8'h10; tok[1] = 8'h20; tok[2] = 8'h30;
        sm[0] = 1'b0; sl[0] = 3; sm[1] = 1'b0; sl[1] = 3;
        run_case("no_merge", 3, 1'b0);

        // Pass limit reached while the grouper keeps reporting merges.
        for (int i = 0; i < 5; i++) tok[i] = DW'(8'ha0 + i);
        sm[0] = 1'b1; sl[0] = 5; sm[1] = 1'b1; sl[1] = 5;
        run_case("pass_limit", 5, 1'b1);

        // Full RAM: the 17th token must be refused.
        for (int i = 0; i < DEPTH; i++) tok[i] = DW'($urandom);
        sm[0] = 1'b0; sl[0] = DEPTH; sm[1] = 1'b0; sl[1] = DEPTH;
        prepare(DEPTH);
        for (int i = 0; i < DEPTH; i++) load_token(tok[i], 1'b0);
        check("full_load_ready", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b1;
        load_data  = 8'hee;
        sticky = 0;
        for (int i = 0; i < 3; i++) begin
            if (ram_we) sticky = 1;
            @(negedge clk);
        end
        load_valid = 1'b0;
        check("full_no_write", sticky, 32'd0);
        check("full_word0_kept", mem0[0], tok[0]);
        pulse_start();
        finish_case("full_ram");

        // Empty word: done with no passes and no tokens.
        prepare(0);
        pulse_start();
        finish_case("empty");

        // Backpressure toggling every other cycle.
        ready_mode = 1;
        gen_random(8);
        run_case("toggle_ready", 8, 1'b0);
        ready_mode = 2;

        // Reset while a pass is outstanding; the late grp_done must be ignored.
        tok[0] = 8'h01; tok[1] = 8'h02; tok[2] = 8'h03; tok[3] = 8'h04;
        exp_q.delete();
        glen_q.delete();
        gscript_q.delete();
        glen_q.push_back(LW'(4));
        gscript_q.push_back({1'b1, LW'(2)});
        cs_base = grp_cs_cnt;
        for (int i = 0; i < 4; i++) load_token(tok[i], 1'b0);
        pulse_start();
        k = 0;
        while (!grp_cs && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rstpass_cs_seen", {31'd0, grp_cs}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sticky = 0;
        for (int i = 0; i < 10; i++) begin
            if (grp_cs || busy || done) sticky = 1;
            @(negedge clk);
        end
        check("rstpass_quiet", sticky, 32'd0);
        check("rstpass_cs_count", grp_cs_cnt - cs_base, 32'd1);
        check_reset_values();
        prepare(0);
        pulse_start();
        finish_case("after_reset_empty");

        for (int c = 0; c < 10; c++) begin
            ready_mode = $urandom_range(0, 2);
            k = $urandom_range(0, DEPTH);
            gen_random(k);
            run_case("random", k, 1'($urandom_range(0, 1)));
        end
        ready_mode = 2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/encoder_pass_ctrl.md
Name: encoder_pass_ctrl

Overview:
Sequencer for the encoder datapath. It loads a host word into the ping-pong working RAMs and launches grouper merge passes. Between passes it swaps the source and destination RAM roles, and it stops when a pass performs no merge, a pass limit is hit, or one token remains. It then streams the final token sequence back to the host. It sits between the host interface and the grouper / input_ram / output_ram pair and owns the RAM port muxes while no pass is running.

Parameters:
ADDR_WIDTH, 4, working-RAM address width; max word length = 2**ADDR_WIDTH tokens
DATA_WIDTH, 8, token width
MAX_PASSES, 8, upper bound on grouper passes per word (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin encoding the loaded word; sampled in IDLE only
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the drain completes
load_valid  in  1  host token valid
load_data  in  DATA_WIDTH  host token
load_ready  out  1  token accepted when load_valid&&load_ready
out_valid  out  1  encoded token valid
out_data  out  DATA_WIDTH  encoded token
out_ready  in  1  host accepts token
out_last  out  1  marks final encoded token
grp_cs  out  1  one-cycle grouper start pulse
grp_done  in  1  grouper pass complete (one-cycle pulse)
grp_merged  in  1  pass merged at least one pair; valid with grp_done
grp_len  in  ADDR_WIDTH+1  token count written by pass; valid with grp_done
grp_len_in  out  ADDR_WIDTH+1  current token count given to grouper
src_sel  out  1  0: input_ram is source, output_ram is dest; 1: reversed
ram_own  out  1  1: controller drives RAM ports; 0: grouper drives them
ram_we  out  1  write enable to the source RAM (load)
ram_addr  out  ADDR_WIDTH  controller address
ram_din  out  DATA_WIDTH  controller write data
ram_dout  in  DATA_WIDTH  source RAM read data, 1-cycle synchronous latency
pass_count  out  $clog2(MAX_PASSES+1)  passes executed for current word

Behaviour:
- Reset values: state IDLE; busy 0, done 0, load_ready 1, out_valid 0, out_last 0, grp_cs 0, src_sel 0, ram_own 1, ram_we 0, ram_addr 0, len 0, pass_count 0.
- rst has priority over every state. Reset mid-pass drops to IDLE immediately. A grp_done arriving after reset is ignored.
- IDLE/LOAD:
  - A load handshake writes load_data to address len of the source RAM (ram_we=1 for that cycle) and increments len.
  - load_ready = (len < 2**ADDR_WIDTH). At a full RAM, extra tokens are not accepted.
  - A load and start in the same cycle: the load completes first, and start is taken with the new len.
- start in IDLE:
  - len==0 goes directly to DONE. No passes run, and done pulses with no output tokens.
  - len==1 goes to DRAIN.
  - Otherwise go to PASS_START.
  - load_ready is 0 from start until return to IDLE.
- PASS_START (1 cycle): grp_cs=1, ram_own=0, grp_len_in=len, pass_count++. Next state PASS_WAIT.
- PASS_WAIT: hold ram_own=0 until grp_done. On grp_done:
  - len <= grp_len, and src_sel toggles in the same cycle.
  - Go to DRAIN if grp_merged==0, or grp_len<=1, or pass_count==MAX_PASSES.
  - Otherwise go to PASS_START; the next grp_cs comes one cycle after grp_done.
  - grp_len > len is a protocol error: clamp len unchanged and go to DRAIN.
- Pass roles:
  - A pass that merged nothing leaves its output equal to its input.
  - After the toggle, src_sel always points at the RAM holding the latest result.
- DRAIN:
  - ram_own=1, with addresses 0..len-1 read from the source RAM.
  - Sequence per token: issue read at cycle t; ram_dout is registered into out_data with out_valid=1 at t+2.
  - Hold out_data and out_valid until out_ready, then issue the next read.
  - Throughput is at most one token per 3 cycles; no pipelining is required.
  - out_last=1 with the token at address len-1.
  - out_ready high while out_valid is low is ignored.
- DONE (1 cycle): done=1. Clear len and pass_count, set src_sel=0, return to IDLE.
- Counter widths:
  - len and grp_len are ADDR_WIDTH+1 bits, so a full RAM (2**ADDR_WIDTH) is representable.
  - The address counter wraps only through the len bound, never by overflow.

Test Plan:
1. Reset, load 4 tokens [0x61,0x62,0x61,0x62], start. Grouper model returns (merged=1,len=2), then (merged=1,len=1) -> 2 grp_cs pulses, src_sel toggles 0→1→0, pass_count=2. One output token with out_last=1, then done.
2. Load 3 tokens; grouper returns merged=0, len=3 on first pass -> exactly 1 pass, src_sel=1. Output equals the 3 tokens from the output_ram model in order, then done.
3. MAX_PASSES=2; grouper always returns merged=1, len unchanged (5) -> exactly 2 passes, then drain of 5 tokens.
4. Load 16 tokens with ADDR_WIDTH=4 -> load_ready drops after the 16th; a 17th token held on load_valid is not written. start with len=0 -> done pulse, no out_valid, no grp_cs.
5. Drain with out_ready toggling every other cycle -> out_data stable while out_valid&&!out_ready; no token lost or duplicated.
6. Assert rst during PASS_WAIT, then deliver grp_done -> controller is in IDLE with reset values; no len update, no grp_cs.
